demux1to4_pipe: RTL and testbench
=================================

# demux1to4_pipe

Registered 1-to-4 demultiplexer with valid/ready handshaking on the input and on each output. It routes one WIDTH-bit source word to one of four sinks, selected by a 2-bit code with the same S1:S0 encoding the ALU 4-to-1 mux uses (00→A, 01→B, 10→C, 11→D). Each output has a one-entry holding register, so a stalled sink blocks only traffic addressed to it. It sits between the ALU result path and the four result consumers: writeback, flags, branch unit and store data.

## Interface
Parameters:
- WIDTH, 32, data width of input and every output.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  in  1  source presents a word.
- in_ready  out  1  block accepts the word this cycle.
- in_sel  in  2  destination select: S1 = in_sel[1], S0 = in_sel[0].
- in_data  in  WIDTH  source word.
- out_valid  out  4  per-output valid; bit 0 = A … bit 3 = D.
- out_ready  in  4  per-output sink ready.
- out_data_a, out_data_b, out_data_c, out_data_d  out  WIDTH each  per-output held words.

## Operation
- Each output k has a slot with a valid bit v[k] and a data register d[k]. The slot drives out_valid[k] = v[k] and out_data_x = d[k].
- in_ready = !rst && (!v[in_sel] || out_ready[in_sel]). This is combinational from in_sel and out_ready, with no registered state in between.
- Accept (fire) when in_valid && in_ready. Slot in_sel then loads d ← in_data and v ← 1.
- Drain of output k when v[k] && out_ready[k]. v[k] ← 0 unless the same slot is reloaded that cycle.
- Load and drain of the same slot in the same cycle: v stays 1 and d takes the new word. There is no bubble, so the slot sustains one word per cycle.
- Slots other than in_sel are unaffected by the input. Any number of slots may drain in the same cycle.
- While v[k]=1 and out_ready[k]=0, d[k] and v[k] hold stable.
- in_sel and in_data are don't-care when in_valid=0. No slot changes on a non-fire cycle except through its own drain.
- All four select codes are legal. There is no error condition.
- Words to the same output leave in acceptance order. There is no ordering guarantee across different outputs.

## Timing
- Reset values, all forced on the first edge with rst=1: v = 4'b0000, every out_data = 0, in_ready = 0 while rst is high.
- Reset mid-operation discards every held word. No drain is reported for discarded words. in_ready rises in the first cycle after rst falls, provided in_valid would find an empty slot.
- Latency: a word accepted at edge N appears with out_valid high right after edge N. The earliest sink accept is edge N+1.
- Throughput: one word per cycle, given that the addressed sink is ready or its slot is empty.
- No combinational path from in_data to any output.

## Structure
- Shared package `demux_pkg`:
  - select constants SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10, SEL_D = 2'b11;
  - NUM_OUT = 4.
- One natural sub-module, `demux_slot` (parameter WIDTH). It holds the v/d register, takes load, load_data and sink_ready, and produces valid, data and can_load.
- The top level instantiates `demux_slot` four times and contains only:
  - the 2-to-4 one-hot decode of in_sel gated by fire;
  - the in_ready mux.

## Test plan
- Reset: hold rst for 2 cycles while in_valid=1 and all out_ready=1 → out_valid=4'b0000, all data 0, in_ready=0 throughout. in_ready goes to 1 in the first cycle after release.
- Routing sweep: all out_ready=1. Send (sel,data) = (0,32'h1111_1111), (1,32'h2222_2222), (2,32'h3333_3333), (3,32'h4444_4444) on consecutive cycles → each word appears exactly one cycle later, only on its own output, as a single-cycle valid.
- Back-pressure isolation: out_ready=4'b1101. Send 32'hAAAA to B, then 32'hBBBB to B → the first is held on B with in_ready=0 for sel=1. In the same cycles, sending 32'hCCCC to C is accepted and delivered. Raise out_ready[1] → 32'hAAAA drains, then 32'hBBBB is accepted.
- Simultaneous load and drain: slot A holds 32'h5 and out_ready[0]=1 as in_valid sends 32'h6 to A → in_ready=1, out_valid[0] stays 1, data changes 5→6 with no bubble.
- Reset mid-operation: fill all four slots with out_ready=0, then assert rst for 1 cycle → out_valid=0 and data 0 next cycle. The held words never appear after release.
- Random stress: 10k cycles of random in_valid, in_sel and out_ready. The scoreboard keeps one queue per output → order is preserved, no loss or duplication, and out_data stays stable while valid and not ready.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - select codes and output count for the 1-to-4 result demultiplexer
package demux_pkg;

  localparam int NUM_OUT = 4;

  // Same S1:S0 encoding as the ALU 4-to-1 mux
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register for a single demux output
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sink_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_load
);

  // A full slot can still take a word when its sink drains it this cycle
  assign can_load = !valid || sink_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && sink_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to4_pipe.sv
// rtl/demux1to4_pipe.sv - registered 1-to-4 demultiplexer with per-output handshaking
module demux1to4_pipe
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data_a,
  output logic [WIDTH-1:0] out_data_b,
  output logic [WIDTH-1:0] out_data_c,
  output logic [WIDTH-1:0] out_data_d
);

  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] can_load;
  logic [WIDTH-1:0]   slot_data [NUM_OUT];
  logic               fire;

  assign in_ready = !rst && can_load[in_sel];
  assign fire     = in_valid && in_ready;

  always_comb begin
    load = '0;
    case (in_sel)
      SEL_A:   load[0] = fire;
      SEL_B:   load[1] = fire;
      SEL_C:   load[2] = fire;
      default: load[3] = fire;
    endcase
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[k]),
      .load_data  (in_data),
      .sink_ready (out_ready[k]),
      .valid      (out_valid[k]),
      .data       (slot_data[k]),
      .can_load   (can_load[k])
    );
  end

  assign out_data_a = slot_data[0];
  assign out_data_b = slot_data[1];
  assign out_data_c = slot_data[2];
  assign out_data_d = slot_data[3];

endmodule

// File: tb/tb_demux1to4_pipe.sv
// tb/tb_demux1to4_pipe.sv - vector table plus per-output scoreboard bench for demux1to4_pipe
module tb_demux1to4_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data_a, out_data_b, out_data_c, out_data_d;
  logic [31:0] od [4];

  int n_cmp = 0;
  int n_bad = 0;
  bit model_known = 1'b0;
  logic [31:0] sb [4][$];

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
  } vec_t;

  vec_t tbl [$];

  demux1to4_pipe #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data_a (out_data_a),
    .out_data_b (out_data_b),
    .out_data_c (out_data_c),
    .out_data_d (out_data_d)
  );

  assign od[0] = out_data_a;
  assign od[1] = out_data_b;
  assign od[2] = out_data_c;
  assign od[3] = out_data_d;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                              input logic [31:0] d, input logic [3:0] o,
                              input logic er, input logic [3:0] eov);
    vec_t t;
    t.rst = r; t.vld = v; t.sel = s; t.data = d; t.ordy = o;
    t.exp_rdy = er; t.exp_ov = eov;
    return t;
  endfunction

  task automatic apply(input logic r, input logic v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] o);
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = o;
    #1;
  endtask

  // Scoreboard checks on settled signals, then advances the model across one rising edge
  task automatic step();
    logic       exp_rdy;
    logic [3:0] exp_ov;
    exp_rdy = !rst && ((sb[in_sel].size() == 0) || out_ready[in_sel]);
    if (model_known) begin
      for (int k = 0; k < 4; k++) exp_ov[k] = (sb[k].size() != 0);
      chk("sb_out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
      chk("sb_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      for (int k = 0; k < 4; k++)
        if (exp_ov[k]) chk($sformatf("sb_data_%0d", k), od[k], sb[k][0]);
    end
    if (rst) begin
      for (int k = 0; k < 4; k++) sb[k].delete();
      model_known = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (sb[k].size() != 0 && out_ready[k]) void'(sb[k].pop_front());
      if (in_valid && exp_rdy) sb[in_sel].push_back(in_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'hF;
    @(negedge clk);

    // Reset held two cycles with a presented word and every sink ready
    apply(1'b1, 1'b1, 2'd0, 32'hDEAD_0001, 4'hF);
    chk("rst_in_ready_c0", {31'd0, in_ready}, 32'd0);
    step();
    apply(1'b1, 1'b1, 2'd2, 32'hDEAD_0002, 4'hF);
    chk("rst_in_ready_c1", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_data_%0d", k), od[k], 32'd0);
    step();
    apply(1'b0, 1'b0, 2'd0, 32'd0, 4'hF);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // routing sweep
    tbl.push_back(mk(0, 1, 2'd0, 32'h1111_1111, 4'hF, 1, 4'b0000));
    tbl.push_back(mk(0, 1, 2'd1, 32'h2222_2222, 4'hF, 1, 4'b0001));
    tbl.push_back(mk(0, 1, 2'd2, 32'h3333_3333, 4'hF, 1, 4'b0010));
    tbl.push_back(mk(0, 1, 2'd3, 32'h4444_4444, 4'hF, 1, 4'b0100));
    tbl.push_back(mk(0, 0, 2'd0, 32'h0,         4'hF, 1, 4'b1000));
    tbl.push_back(mk(0, 0, 2'd0, 32'h0,         4'hF, 1, 4'b0000));
    // back-pressure isolation on B
    tbl.push_back(mk(0, 1, 2'd1, 32'hAAAA,      4'b1101, 1, 4'b0000));
    tbl.push_back(mk(0, 1, 2'd1, 32'hBBBB,      4'b1101, 0, 4'b0010));
    tbl.push_back(mk(0, 1, 2'd2, 32'hCCCC,      4'b1101, 1, 4'b0010));
    tbl.push_back(mk(0, 1, 2'd1, 32'hBBBB,      4'b1101, 0, 4'b0110));
    tbl.push_back(mk(0, 1, 2'd1, 32'hBBBB,      4'hF,    1, 4'b0010));
    tbl.push_back(mk(0, 0, 2'd1, 32'h0,         4'hF,    1, 4'b0010));
    tbl.push_back(mk(0, 0, 2'd1, 32'h0,         4'hF,    1, 4'b0000));
    // simultaneous load and drain on A
    tbl.push_back(mk(0, 1, 2'd0, 32'h5,         4'b0000, 1, 4'b0000));
    tbl.push_back(mk(0, 1, 2'd0, 32'h6,         4'b0001, 1, 4'b0001));
    tbl.push_back(mk(0, 0, 2'd0, 32'h0,         4'b0001, 1, 4'b0001));
    tbl.push_back(mk(0, 0, 2'd0, 32'h0,         4'hF,    1, 4'b0000));
    // fill all slots, then reset mid-operation
    tbl.push_back(mk(0, 1, 2'd0, 32'h100,       4'b0000, 1, 4'b0000));
    tbl.push_back(mk(0, 1, 2'd1, 32'h101,       4'b0000, 1, 4'b0001));
    tbl.push_back(mk(0, 1, 2'd2, 32'h102,       4'b0000, 1, 4'b0011));
    tbl.push_back(mk(0, 1, 2'd3, 32'h103,       4'b0000, 1, 4'b0111));
    tbl.push_back(mk(0, 1, 2'd0, 32'h104,       4'b0000, 0, 4'b1111));
    tbl.push_back(mk(1, 0, 2'd0, 32'h0,         4'hF,    0, 4'b1111));
    tbl.push_back(mk(0, 0, 2'd0, 32'h0,         4'hF,    1, 4'b0000));
    tbl.push_back(mk(0, 0, 2'd3, 32'h0,         4'hF,    1, 4'b0000));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
      chk($sformatf("v%0d_out_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].exp_ov});
      if (i == 14) chk("v14_hold_a", out_data_a, 32'h5);
      if (i == 15) chk("v15_new_a", out_data_a, 32'h6);
      step();
    end
    for (int k = 0; k < 4; k++) chk($sformatf("midrst_data_%0d", k), od[k], 32'd0);

    // Random stress; the scoreboard checks order, loss, duplication and hold stability
    for (int c = 0; c < 10000; c++) begin
      apply(1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            $urandom, 4'($urandom));
      step();
    end
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 1'b0, 2'd0, 32'd0, 4'hF);
      step();
    end
    chk("final_out_valid", {28'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
